// File: rtl/ws2812_cmd_parser.sv
// Framed byte-stream command parser feeding the ws2812 driver write port.
// Packets: HDR, IDX, C0, C1, C2, CHK with CHK = IDX^C0^C1^C2; SET writes one LED, FILL writes all.
module ws2812_cmd_parser #(
  parameter int unsigned NUM_LEDS   = 8,
  parameter int unsigned CLK_MHZ    = 12,
  parameter int unsigned TIMEOUT_US = 1000,
  parameter logic [7:0]  HDR_SET    = 8'hA5,
  parameter logic [7:0]  HDR_FILL   = 8'hA6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        write,
  output logic        pkt_err,
  output logic        busy
);

  localparam int unsigned TIMEOUT_CYCLES = CLK_MHZ * TIMEOUT_US;
  localparam int unsigned GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] LAST_LED = 8'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    StIdle, StIdx, StC0, StC1, StC2, StChk, StFill
  } state_e;

  state_e           state_q, state_d;
  logic             is_fill_q, is_fill_d;
  logic [7:0]       idx_q, idx_d;
  logic [23:0]      col_q, col_d;
  logic [7:0]       xor_q, xor_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             write_q, write_d;
  logic             pkt_err_q, pkt_err_d;
  logic [7:0]       led_num_q, led_num_d;
  logic [23:0]      rgb_q, rgb_d;

  logic accept;
  logic in_pkt;

  assign in_ready = !reset && (state_q != StFill);
  assign accept   = in_valid && in_ready;
  assign in_pkt   = (state_q == StIdx) || (state_q == StC0) || (state_q == StC1) ||
                    (state_q == StC2) || (state_q == StChk);

  always_comb begin
    state_d   = state_q;
    is_fill_d = is_fill_q;
    idx_d     = idx_q;
    col_d     = col_q;
    xor_d     = xor_q;
    gap_d     = gap_q;
    write_d   = 1'b0;
    pkt_err_d = 1'b0;
    led_num_d = led_num_q;
    rgb_d     = rgb_q;

    // Inter-byte gap watchdog; an accept in the limit cycle still wins.
    if (in_pkt) begin
      if (accept) begin
        gap_d = '0;
      end else if (gap_q == GAP_LAST) begin
        gap_d     = '0;
        state_d   = StIdle;
        pkt_err_d = 1'b1;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (accept && ((in_data == HDR_SET) || (in_data == HDR_FILL))) begin
          is_fill_d = (in_data == HDR_FILL);
          xor_d     = '0;
          gap_d     = '0;
          state_d   = StIdx;
        end
      end
      StIdx: begin
        if (accept) begin
          idx_d   = in_data;
          xor_d   = xor_q ^ in_data;
          state_d = StC0;
        end
      end
      StC0, StC1, StC2: begin
        if (accept) begin
          col_d   = {col_q[15:0], in_data};
          xor_d   = xor_q ^ in_data;
          state_d = (state_q == StC0) ? StC1 : (state_q == StC1) ? StC2 : StChk;
        end
      end
      StChk: begin
        if (accept) begin
          state_d = StIdle;
          if (in_data != xor_q) begin
            pkt_err_d = 1'b1;
          end else if (is_fill_q) begin
            write_d   = 1'b1;
            led_num_d = '0;
            rgb_d     = col_q;
            state_d   = StFill;
          end else if ({24'd0, idx_q} >= NUM_LEDS) begin
            pkt_err_d = 1'b1;
          end else begin
            write_d   = 1'b1;
            led_num_d = idx_q;
            rgb_d     = col_q;
          end
        end
      end
      StFill: begin
        // led_num_q is the index written this cycle; stop after the last LED.
        if (led_num_q == LAST_LED) begin
          state_d = StIdle;
        end else begin
          write_d   = 1'b1;
          led_num_d = led_num_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      is_fill_q <= 1'b0;
      idx_q     <= '0;
      col_q     <= '0;
      xor_q     <= '0;
      gap_q     <= '0;
      write_q   <= 1'b0;
      pkt_err_q <= 1'b0;
      led_num_q <= '0;
      rgb_q     <= '0;
    end else begin
      state_q   <= state_d;
      is_fill_q <= is_fill_d;
      idx_q     <= idx_d;
      col_q     <= col_d;
      xor_q     <= xor_d;
      gap_q     <= gap_d;
      write_q   <= write_d;
      pkt_err_q <= pkt_err_d;
      led_num_q <= led_num_d;
      rgb_q     <= rgb_d;
    end
  end

  assign write    = write_q;
  assign pkt_err  = pkt_err_q;
  assign led_num  = led_num_q;
  assign rgb_data = rgb_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ws2812_cmd_parser.sv
// Bench for ws2812_cmd_parser: directed cases plus random packet streams checked
// against a packet-level reference model with cycle-stamped expected events.
module tb_ws2812_cmd_parser;

  localparam int unsigned NL = 8;
  localparam int unsigned T  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        write;
  logic        pkt_err;
  logic        busy;

  ws2812_cmd_parser #(
    .NUM_LEDS  (NL),
    .CLK_MHZ   (1),
    .TIMEOUT_US(T)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .rgb_data(rgb_data),
    .led_num (led_num),
    .write   (write),
    .pkt_err (pkt_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          stamp;
    logic [7:0]  led;
    logic [23:0] rgb;
  } wr_t;

  wr_t exp_wr[$];
  wr_t act_wr[$];
  int  exp_err[$];
  int  act_err[$];

  int checks   = 0;
  int failures = 0;

  // Outputs are registered, so the falling edge sees them settled.
  always @(negedge clk) begin
    if (write) act_wr.push_back('{cyc, led_num, rgb_data});
    if (pkt_err) act_err.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: packet rules applied to accepted bytes and their stamps
  // (stamp = cycle at which the effect of accepting the byte is first visible).
  logic [7:0] m_buf[6];
  int         m_len  = 0;
  int         m_last = 0;

  task automatic model_byte(input logic [7:0] b, input int t);
    logic [7:0]  chk;
    logic [23:0] rgb;
    if (m_len > 0 && (t - m_last) > int'(T)) begin
      exp_err.push_back(m_last + int'(T));
      m_len = 0;
    end
    if (m_len == 0) begin
      if (b == 8'hA5 || b == 8'hA6) begin
        m_buf[0] = b;
        m_len    = 1;
        m_last   = t;
      end
    end else begin
      m_buf[m_len] = b;
      m_len++;
      m_last = t;
      if (m_len == 6) begin
        m_len = 0;
        chk   = m_buf[1] ^ m_buf[2] ^ m_buf[3] ^ m_buf[4];
        rgb   = {m_buf[2], m_buf[3], m_buf[4]};
        if (chk != m_buf[5]) exp_err.push_back(t);
        else if (m_buf[0] == 8'hA6) begin
          for (int k = 0; k < int'(NL); k++) exp_wr.push_back('{t + k, 8'(k), rgb});
        end else if (int'(m_buf[1]) >= int'(NL)) exp_err.push_back(t);
        else exp_wr.push_back('{t, m_buf[1], rgb});
      end
    end
  endtask

  // Only valid after the stream has been quiet for more than T cycles.
  task automatic model_flush();
    if (m_len > 0) exp_err.push_back(m_last + int'(T));
    m_len = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_eq("accept_wait", 32'(in_ready), 32'd1);
    end else begin
      model_byte(b, cyc + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] idx, input logic [23:0] col,
                          input logic [7:0] chk_flip);
    logic [7:0] chk;
    chk = idx ^ col[23:16] ^ col[15:8] ^ col[7:0] ^ chk_flip;
    send_byte(hdr, 0);
    send_byte(idx, 0);
    send_byte(col[23:16], 0);
    send_byte(col[15:8], 0);
    send_byte(col[7:0], 0);
    send_byte(chk, 0);
  endtask

  task automatic compare_all();
    int n;
    repeat (T + NL + 4) @(negedge clk);
    model_flush();
    check_eq("write_count", 32'(act_wr.size()), 32'(exp_wr.size()));
    n = (act_wr.size() < exp_wr.size()) ? act_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++) begin
      check_eq("write_cycle", 32'(act_wr[i].stamp), 32'(exp_wr[i].stamp));
      check_eq("led_num", 32'(act_wr[i].led), 32'(exp_wr[i].led));
      check_eq("rgb_data", 32'(act_wr[i].rgb), 32'(exp_wr[i].rgb));
    end
    check_eq("err_count", 32'(act_err.size()), 32'(exp_err.size()));
    n = (act_err.size() < exp_err.size()) ? act_err.size() : exp_err.size();
    for (int i = 0; i < n; i++) check_eq("err_cycle", 32'(act_err[i]), 32'(exp_err[i]));
    act_wr.delete();
    exp_wr.delete();
    act_err.delete();
    exp_err.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_write"}, 32'(write), 32'd0);
    check_eq({tag, "_pkt_err"}, 32'(pkt_err), 32'd0);
    check_eq({tag, "_led_num"}, 32'(led_num), 32'd0);
    check_eq({tag, "_rgb"}, 32'(rgb_data), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int         kind;
    logic [7:0] b;
    logic [7:0] pkt[6];
    int         cut;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("ready_after_reset", 32'(in_ready), 32'd1);

    // SET
    send_pkt(8'hA5, 8'h03, 24'h112233, 8'h00);
    compare_all();
    check_eq("set_led_hold", 32'(led_num), 32'd3);
    check_eq("set_rgb_hold", 32'(rgb_data), 32'h112233);

    // FILL with in_ready low across all writes
    send_pkt(8'hA6, 8'h00, 24'hFF0080, 8'h00);
    for (int k = 0; k < int'(NL); k++) begin
      check_eq("fill_ready_low", 32'(in_ready), 32'd0);
      check_eq("fill_write", 32'(write), 32'd1);
      check_eq("fill_led", 32'(led_num), 32'(k));
      @(negedge clk);
    end
    check_eq("fill_ready_back", 32'(in_ready), 32'd1);
    check_eq("fill_write_end", 32'(write), 32'd0);
    check_eq("fill_busy_end", 32'(busy), 32'd0);
    compare_all();

    // Bad checksum then good packet; junk bytes; bad index
    send_pkt(8'hA5, 8'h01, 24'h102030, 8'h30);
    send_pkt(8'hA5, 8'h05, 24'hABCDEF, 8'h00);
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_pkt(8'hA5, 8'h08, 24'h010203, 8'h00);
    compare_all();

    // Timeout, then a normal packet
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    repeat (T + 2) @(negedge clk);
    check_eq("timeout_busy", 32'(busy), 32'd0);
    send_pkt(8'hA5, 8'h02, 24'h445566, 8'h00);
    compare_all();

    // Byte arriving exactly at the last allowed cycle is accepted
    send_byte(8'hA5, 0);
    send_byte(8'h04, T - 1);
    send_byte(8'h01, T - 1);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04 ^ 8'h01 ^ 8'h02 ^ 8'h03, T - 1);
    compare_all();

    // Randomized packet stream
    for (int p = 0; p < 60; p++) begin
      kind   = $urandom_range(0, 5);
      pkt[0] = (kind == 1) ? 8'hA6 : 8'hA5;
      pkt[1] = (kind == 1) ? 8'($urandom) : 8'($urandom_range(0, 10));
      pkt[2] = 8'($urandom);
      pkt[3] = 8'($urandom);
      pkt[4] = 8'($urandom);
      pkt[5] = pkt[1] ^ pkt[2] ^ pkt[3] ^ pkt[4];
      if (kind == 2) pkt[5] = pkt[5] ^ 8'(1 << $urandom_range(0, 7));
      if (kind == 3) begin
        b = 8'($urandom);
        if (b == 8'hA5 || b == 8'hA6) b = 8'h00;
        send_byte(b, $urandom_range(0, 2));
      end
      cut = (kind == 4) ? $urandom_range(1, 5) : 6;
      for (int i = 0; i < cut; i++) begin
        if (kind == 5 && i == 3) send_byte(pkt[i], $urandom_range(T - 1, T));
        else send_byte(pkt[i], $urandom_range(0, 2));
      end
      if (kind == 4) repeat (T + 1) @(negedge clk);
    end
    compare_all();

    // Reset during the 4th fill write
    send_pkt(8'hA6, 8'h11, 24'h00AA55, 8'h00);
    repeat (3) @(negedge clk);
    check_eq("pre_reset_led", 32'(led_num), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("fill_reset");
    check_eq("fill_reset_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_reset_ready", 32'(in_ready), 32'd1);
    while (exp_wr.size() > 4) void'(exp_wr.pop_back());
    m_len = 0;
    compare_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
